rtc_key_scheduler: RTL and testbench

Consumer stage directly downstream of the RTC clock divider. Samples the divider's clk_5s and clk_500Hz outputs as data inputs in the sys_clk domain and edge-detects them. Each clk_5s rising edge advances a 16-bit rotating key through an LFSR. Each clk_500Hz rising edge advances a 4-digit multiplexed 7-segment scan showing the current key in hex.

---
 rtl/rtc_pkg.sv | 30 +++
 rtl/rtc_hex_to_7seg.sv | 37 +++
 rtl/rtc_key_scheduler.sv | 121 ++++++++++++
 tb/tb_rtc_key_scheduler.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// ============================================================================
// rtc_pkg : shared types and constants for the RTC key scheduler
// Rev 1.0
// ============================================================================
`default_nettype none

package rtc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic [15:0] ZERO_SUB_DEFAULT = 16'hACE1;

  localparam int TAP_A = 15;
  localparam int TAP_B = 13;
  localparam int TAP_C = 12;
  localparam int TAP_D = 10;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [15:0] lfsr_next(input logic [15:0] k);
    return {k[14:0], k[TAP_A] ^ k[TAP_B] ^ k[TAP_C] ^ k[TAP_D]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/rtc_hex_to_7seg.sv
// ============================================================================
// rtc_hex_to_7seg : 4-bit nibble to active-low {g,f,e,d,c,b,a} segments
// Rev 1.0
// ============================================================================
`default_nettype none

module rtc_hex_to_7seg (
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'b1111111;
    case (nibble_i)
      4'h0: seg_o = 7'b1000000;
      4'h1: seg_o = 7'b1111001;
      4'h2: seg_o = 7'b0100100;
      4'h3: seg_o = 7'b0110000;
      4'h4: seg_o = 7'b0011001;
      4'h5: seg_o = 7'b0010010;
      4'h6: seg_o = 7'b0000010;
      4'h7: seg_o = 7'b1111000;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0010000;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b0000011;
      4'hC: seg_o = 7'b1000110;
      4'hD: seg_o = 7'b0100001;
      4'hE: seg_o = 7'b0000110;
      4'hF: seg_o = 7'b0001110;
      default: seg_o = 7'b1111111;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/rtc_key_scheduler.sv
// ============================================================================
// rtc_key_scheduler : LFSR key rotation on clk_5s ticks, 4-digit hex scan
// Rev 1.0
// ============================================================================
`default_nettype none

module rtc_key_scheduler
  import rtc_pkg::*;
#(
  parameter logic [15:0] ZERO_SUB    = ZERO_SUB_DEFAULT,
  parameter int          COUNT_WIDTH = 8
) (
  input  logic                   sys_clk,
  input  logic                   rst,
  input  logic                   clk_500Hz,
  input  logic                   clk_5s,
  input  logic                   enable,
  input  logic                   seed_valid,
  input  logic [15:0]            seed,
  output logic [15:0]            key,
  output logic                   key_changed,
  output logic [COUNT_WIDTH-1:0] key_count,
  output logic [1:0]             digit_sel,
  output logic [3:0]             an,
  output logic [6:0]             seg
);

  state_e                 state_q, state_d;
  logic [15:0]            key_q, key_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   changed_q, changed_d;
  logic [1:0]             digit_q, digit_d;
  logic                   prev_5s_q, prev_500_q;

  logic                   tick_5s, tick_500;
  logic [3:0]             nibble;
  logic [6:0]             seg_raw;

  assign tick_5s  = clk_5s & ~prev_5s_q;
  assign tick_500 = clk_500Hz & ~prev_500_q;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (seed_valid || state_q != IDLE) begin
      state_d = enable ? RUN : HOLD;
    end
  end

  always_comb begin
    key_d     = key_q;
    count_d   = count_q;
    changed_d = 1'b0;
    digit_d   = digit_q;
    // A seed load takes priority and swallows a coincident key tick.
    if (seed_valid) begin
      key_d     = (seed == 16'h0000) ? ZERO_SUB : seed;
      count_d   = '0;
      changed_d = 1'b1;
    end else if (state_q == RUN && tick_5s) begin
      key_d     = lfsr_next(key_q);
      count_d   = count_q + COUNT_WIDTH'(1);
      changed_d = 1'b1;
    end
    if (state_q != IDLE && tick_500) begin
      digit_d = digit_q + 2'd1;
    end
  end

  // Edge history resets high so a level already present at release is not a tick.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      key_q      <= 16'h0000;
      count_q    <= '0;
      changed_q  <= 1'b0;
      digit_q    <= 2'd0;
      prev_5s_q  <= 1'b1;
      prev_500_q <= 1'b1;
    end else begin
      key_q      <= key_d;
      count_q    <= count_d;
      changed_q  <= changed_d;
      digit_q    <= digit_d;
      prev_5s_q  <= clk_5s;
      prev_500_q <= clk_500Hz;
    end
  end

  always_comb begin
    nibble = key_q[3:0];
    case (digit_q)
      2'd0: nibble = key_q[3:0];
      2'd1: nibble = key_q[7:4];
      2'd2: nibble = key_q[11:8];
      2'd3: nibble = key_q[15:12];
      default: nibble = key_q[3:0];
    endcase
  end

  rtc_hex_to_7seg u_hex (
    .nibble_i (nibble),
    .seg_o    (seg_raw)
  );

  assign key         = key_q;
  assign key_changed = changed_q;
  assign key_count   = count_q;
  assign digit_sel   = digit_q;
  assign an          = (state_q == IDLE) ? 4'b1111 : ~(4'b0001 << digit_q);
  assign seg         = (state_q == IDLE) ? SEG_BLANK : seg_raw;

endmodule

`default_nettype wire

// File: tb/tb_rtc_key_scheduler.sv
// Bench for rtc_key_scheduler: directed steps plus random traffic against a
// cycle-level behavioural model of the key/scan rules.
`default_nettype none

module tb_rtc_key_scheduler;

  logic        sys_clk = 1'b0;
  logic        rst, clk_500Hz, clk_5s, enable, seed_valid;
  logic [15:0] seed;
  logic [15:0] key;
  logic        key_changed;
  logic [7:0]  key_count;
  logic [1:0]  digit_sel;
  logic [3:0]  an;
  logic [6:0]  seg;

  always #5 sys_clk = ~sys_clk;

  rtc_key_scheduler #(.ZERO_SUB(16'hACE1), .COUNT_WIDTH(8)) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .clk_500Hz   (clk_500Hz),
    .clk_5s      (clk_5s),
    .enable      (enable),
    .seed_valid  (seed_valid),
    .seed        (seed),
    .key         (key),
    .key_changed (key_changed),
    .key_count   (key_count),
    .digit_sel   (digit_sel),
    .an          (an),
    .seg         (seg)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Model: "seeded" = a seed loaded since reset; "rotating" = enable as seen
  // by the design after the seed (takes effect one cycle later).
  logic [15:0] m_key;
  logic [7:0]  m_count;
  logic        m_changed, m_seeded, m_rotating, m_last5, m_last500;
  logic [1:0]  m_digit;

  logic [6:0] SEG_TAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  function automatic logic [15:0] lfsr(input logic [15:0] k);
    return {k[14:0], k[15] ^ k[13] ^ k[12] ^ k[10]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic       rise5, rise500;
    logic [3:0] e_an;
    logic [3:0] nib;
    if (rst) begin
      m_key = 16'h0; m_count = 8'h0; m_changed = 1'b0; m_digit = 2'd0;
      m_seeded = 1'b0; m_rotating = 1'b0; m_last5 = 1'b1; m_last500 = 1'b1;
    end else begin
      rise5     = clk_5s && !m_last5;
      rise500   = clk_500Hz && !m_last500;
      m_changed = 1'b0;
      if (seed_valid) begin
        m_key = (seed == 16'h0) ? 16'hACE1 : seed;
        m_count = 8'h0; m_changed = 1'b1;
      end else if (m_seeded && m_rotating && rise5) begin
        m_key = lfsr(m_key);
        m_count = 8'((int'(m_count) + 1) % 256);
        m_changed = 1'b1;
      end
      if (m_seeded && rise500) m_digit = 2'((int'(m_digit) + 1) % 4);
      if (m_seeded || seed_valid) m_rotating = enable;
      m_seeded  = m_seeded || seed_valid;
      m_last5   = clk_5s;
      m_last500 = clk_500Hz;
    end
    @(posedge sys_clk);
    #1;
    e_an = 4'b1111;
    e_an[m_digit] = !m_seeded;
    nib = m_key[4*m_digit +: 4];
    check("key", 32'(key), 32'(m_key));
    check("key_changed", 32'(key_changed), 32'(m_changed));
    check("key_count", 32'(key_count), 32'(m_count));
    check("digit_sel", 32'(digit_sel), 32'(m_seeded ? m_digit : 2'd0));
    check("an", 32'(an), 32'(e_an));
    check("seg", 32'(seg), 32'(m_seeded ? SEG_TAB[nib] : 7'h7F));
  endtask

  task automatic pulse5();
    clk_5s = 1'b1; step();
    clk_5s = 1'b0; repeat ($urandom_range(1, 3)) step();
  endtask

  task automatic pulse500();
    clk_500Hz = 1'b1; step();
    clk_500Hz = 1'b0; step();
  endtask

  task automatic load(input logic [15:0] s);
    seed = s; seed_valid = 1'b1; step();
    seed_valid = 1'b0; seed = 16'($urandom);
  endtask

  initial begin
    rst = 1'b1; clk_5s = 1'b1; clk_500Hz = 1'b1;
    enable = 1'b0; seed_valid = 1'b0; seed = 16'h0;

    // Reset with both divider inputs already high
    repeat (3) step();
    rst = 1'b0;
    repeat (4) step();
    check("rst_key", 32'(key), 32'h0);
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_digit", 32'(digit_sel), 32'h0);

    // Ticks before any seed are ignored
    clk_5s = 1'b0; clk_500Hz = 1'b0; step();
    pulse5(); pulse500();
    check("idle_key", 32'(key), 32'h0);

    // Seed load and one LFSR step
    enable = 1'b1;
    load(16'hACE1);
    check("seed_key", 32'(key), 32'hACE1);
    check("seed_changed", 32'(key_changed), 32'h1);
    check("seed_count", 32'(key_count), 32'h0);
    clk_5s = 1'b1; step();
    check("step_key", 32'(key), 32'h59C3);
    check("step_count", 32'(key_count), 32'h1);
    check("step_changed", 32'(key_changed), 32'h1);
    clk_5s = 1'b0; step();
    check("step_changed_once", 32'(key_changed), 32'h0);

    // Zero seed substitution and seed/tick collision
    load(16'h0000);
    check("zero_seed", 32'(key), 32'hACE1);
    step();
    clk_5s = 1'b1; seed = 16'h1234; seed_valid = 1'b1; step();
    clk_5s = 1'b0; seed_valid = 1'b0; step(); step();
    check("collide_key", 32'(key), 32'h1234);
    check("collide_count", 32'(key_count), 32'h0);

    // Display scan on key 59C3
    load(16'h59C3);
    while (digit_sel != 2'd0) pulse500();
    check("scan0_an", 32'(an), 32'hE);
    check("scan0_seg", 32'(seg), 32'h30);
    pulse500();
    check("scan1_an", 32'(an), 32'hD);
    check("scan1_seg", 32'(seg), 32'h46);
    pulse500();
    check("scan2_an", 32'(an), 32'hB);
    pulse500();
    check("scan3_an", 32'(an), 32'h7);
    pulse500();
    check("scan_wrap_an", 32'(an), 32'hE);

    // Hold: key frozen, display keeps scanning
    enable = 1'b0; step(); step();
    pulse5(); pulse5();
    check("hold_key", 32'(key), 32'h59C3);
    check("hold_count", 32'(key_count), 32'h0);
    pulse500();
    check("hold_scan_an", 32'(an), 32'hD);

    // Count wrap after 256 rotations from a random seed
    enable = 1'b1; step();
    load(16'($urandom));
    for (int i = 0; i < 256; i++) begin
      clk_500Hz = 1'($urandom);
      pulse5();
    end
    check("wrap_count", 32'(key_count), 32'h0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      clk_5s     = 1'($urandom);
      clk_500Hz  = 1'($urandom);
      if ($urandom_range(0, 15) == 0) enable = ~enable;
      seed_valid = ($urandom_range(0, 24) == 0);
      seed       = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      step();
    end
    seed_valid = 1'b0; clk_5s = 1'b0; clk_500Hz = 1'b0; enable = 1'b1;
    step(); step();

    // Mid-operation reset, then ticks ignored until the next seed
    load(16'($urandom));
    step();
    repeat (5) pulse5();
    for (int i = 0; i < 4 && digit_sel != 2'd2; i++) pulse500();
    check("pre_rst_count", 32'(key_count), 32'h5);
    check("pre_rst_digit", 32'(digit_sel), 32'h2);
    rst = 1'b1; step();
    rst = 1'b0; clk_5s = 1'b0; clk_500Hz = 1'b0; step();
    check("mid_rst_key", 32'(key), 32'h0);
    check("mid_rst_count", 32'(key_count), 32'h0);
    check("mid_rst_an", 32'(an), 32'hF);
    repeat (3) pulse5();
    pulse500();
    check("post_rst_key", 32'(key), 32'h0);
    load(16'hACE1);
    step();
    pulse5();
    check("reseed_step", 32'(key), 32'h59C3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
